// File: rtl/registers_bank_mp.sv
// rtl/registers_bank_mp.sv - multi-port register bank with registered reads, write-first bypass and streaming dump engine
module registers_bank_mp #(
   parameter int REGISTERS_BANK_SIZE = 32,
   parameter int REGISTERS_SIZE      = 32,
   parameter int NUM_READ_PORTS      = 2,
   parameter int NUM_WRITE_PORTS     = 2,
   parameter int ZERO_REG            = 1,
   localparam int AW = (REGISTERS_BANK_SIZE > 1) ? $clog2(REGISTERS_BANK_SIZE) : 1
) (
   input  logic                                      i_clk,
   input  logic                                      i_reset,
   input  logic [NUM_WRITE_PORTS-1:0]                i_write_enable,
   input  logic [NUM_WRITE_PORTS*AW-1:0]             i_addr_wr,
   input  logic [NUM_WRITE_PORTS*REGISTERS_SIZE-1:0] i_bus_wr,
   input  logic                                      i_read_enable,
   input  logic [NUM_READ_PORTS*AW-1:0]              i_addr_rd,
   output logic [NUM_READ_PORTS*REGISTERS_SIZE-1:0]  o_bus_rd,
   input  logic                                      i_dump_start,
   input  logic                                      i_dump_ready,
   output logic                                      o_dump_valid,
   output logic [AW-1:0]                             o_dump_addr,
   output logic [REGISTERS_SIZE-1:0]                 o_dump_data,
   output logic                                      o_dump_busy,
   output logic                                      o_dump_done,
   output logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] o_bus_debug
);

   localparam int N  = REGISTERS_BANK_SIZE;
   localparam int DW = REGISTERS_SIZE;
   localparam int R  = NUM_READ_PORTS;
   localparam int W  = NUM_WRITE_PORTS;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   logic [DW-1:0]   r_regs [N];
   logic [R*DW-1:0] r_bus_rd;
   logic [R*DW-1:0] w_rd_next;

   state_t          r_state;
   state_t          w_state_next;
   logic [AW-1:0]   r_dump_idx;
   logic [DW-1:0]   r_dump_data;
   logic            w_dump_load;
   logic [AW-1:0]   w_dump_load_idx;

   // Value a read of address a captures on this edge: array content, overridden
   // by any write landing on the same edge (later ports take priority).
   // Out-of-range addresses and the hardwired zero register return 0.
   function automatic logic [DW-1:0] f_read_bypassed(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      logic          valid_addr;
      v          = '0;
      valid_addr = (32'(a) < N) && !((ZERO_REG != 0) && (a == '0));
      for (int i = 0; i < N; i++) begin
         if (a == AW'(i)) begin
            v = r_regs[i];
         end
      end
      for (int k = 0; k < W; k++) begin
         if (i_write_enable[k] && (i_addr_wr[k*AW +: AW] == a)) begin
            v = i_bus_wr[k*DW +: DW];
         end
      end
      if (!valid_addr) begin
         v = '0;
      end
      return v;
   endfunction

   // Register array update; iterating ports in ascending order lets the highest port win
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < N; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         for (int k = 0; k < W; k++) begin
            for (int i = 0; i < N; i++) begin
               if (i_write_enable[k] && (i_addr_wr[k*AW +: AW] == AW'(i)) &&
                   !((ZERO_REG != 0) && (i == 0))) begin
                  r_regs[i] <= i_bus_wr[k*DW +: DW];
               end
            end
         end
      end
   end

   // Next value for every read port, including same-edge write bypass
   always_comb begin
      w_rd_next = '0;
      for (int j = 0; j < R; j++) begin
         w_rd_next[j*DW +: DW] = f_read_bypassed(i_addr_rd[j*AW +: AW]);
      end
   end

   // Registered read ports; hold when reads are disabled
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_bus_rd <= '0;
      end else if (i_read_enable) begin
         r_bus_rd <= w_rd_next;
      end
   end

   assign o_bus_rd = r_bus_rd;

   // Flat debug view of the array, register 0 masked when hardwired
   always_comb begin
      o_bus_debug = '0;
      for (int i = 0; i < N; i++) begin
         if ((ZERO_REG != 0) && (i == 0)) begin
            o_bus_debug[i*DW +: DW] = '0;
         end else begin
            o_bus_debug[i*DW +: DW] = r_regs[i];
         end
      end
   end

   // Dump FSM state register
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Dump FSM next state, beat load requests and handshake outputs
   always_comb begin
      w_state_next    = r_state;
      w_dump_load     = 1'b0;
      w_dump_load_idx = r_dump_idx;
      o_dump_valid    = 1'b0;
      o_dump_busy     = 1'b0;
      o_dump_done     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_dump_start) begin
               w_state_next    = ST_STREAM;
               w_dump_load     = 1'b1;
               w_dump_load_idx = '0;
            end
         end
         ST_STREAM: begin
            o_dump_valid = 1'b1;
            o_dump_busy  = 1'b1;
            if (i_dump_ready) begin
               if (r_dump_idx == AW'(N - 1)) begin
                  w_state_next = ST_DONE;
               end else begin
                  w_dump_load     = 1'b1;
                  w_dump_load_idx = r_dump_idx + AW'(1);
               end
            end
         end
         ST_DONE: begin
            o_dump_busy  = 1'b1;
            o_dump_done  = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Beat index and data; data is captured once per beat so a stalled beat stays stable
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_dump_idx  <= '0;
         r_dump_data <= '0;
      end else if (w_dump_load) begin
         r_dump_idx  <= w_dump_load_idx;
         r_dump_data <= f_read_bypassed(w_dump_load_idx);
      end
   end

   assign o_dump_addr = r_dump_idx;
   assign o_dump_data = r_dump_data;

endmodule
